// File: rtl/video_timing_m.sv
// 640x480@60 raster generator: VGA sync, 256x240 logical pixel coordinates, vblank pulses.
// Optional vblank interrupt is built only when GPU_VBLANK_IRQ_EN is defined.
module video_timing_m (
  input  logic       gpu_clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic [7:0] current_x,
  output logic [7:0] current_y,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count,
  output logic       irq,
  input  logic       irq_ack
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] X_BEGIN  = 10'd64;
  localparam logic [9:0] X_END    = 10'd576;
  localparam logic [9:0] HS_BEGIN = 10'd656;
  localparam logic [9:0] HS_END   = 10'd751;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] VS_BEGIN = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] frame_cnt;
  logic       frame_start_r;
  logic       vblank_start_r;
  logic       line_end;
  logic       frame_end;
  logic       vblank_edge;

  assign line_end    = (h_cnt == H_LAST);
  assign frame_end   = line_end && (v_cnt == V_LAST);
  assign vblank_edge = line_end && (v_cnt == V_VIS - 10'd1);

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Pulses are computed from the pre-wrap counters so they line up with (0,0) / (0,480).
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      frame_start_r  <= 1'b0;
      vblank_start_r <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      frame_start_r  <= frame_end;
      vblank_start_r <= vblank_edge;
      if (frame_end)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    hcount    = h_cnt;
    vcount    = v_cnt;
    vblank    = (v_cnt >= V_VIS);
    visible   = (h_cnt >= X_BEGIN) && (h_cnt < X_END) && !vblank;
    current_x = visible ? 8'((h_cnt - X_BEGIN) >> 1) : '0;
    current_y = !vblank ? 8'(v_cnt >> 1) : '0;
    hsync     = !((h_cnt >= HS_BEGIN) && (h_cnt <= HS_END));
    vsync     = !((v_cnt >= VS_BEGIN) && (v_cnt <= VS_END));
  end

  assign frame_start  = frame_start_r;
  assign vblank_start = vblank_start_r;
  assign frame_count  = frame_cnt;

`ifdef GPU_VBLANK_IRQ_EN
  logic irq_r;

  // Set has priority over a coincident acknowledge.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst)
      irq_r <= 1'b0;
    else if (vblank_edge)
      irq_r <= 1'b1;
    else if (irq_ack)
      irq_r <= 1'b0;
  end

  assign irq = irq_r;
`else
  logic irq_ack_unused;
  assign irq_ack_unused = irq_ack;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_m.sv
// Directed bench for video_timing_m: decode vectors plus reset, vblank, irq and frame-wrap sequences.
// Counters are preloaded by force/release so a full frame never has to be simulated.
module tb_video_timing_m;

  logic       gpu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq_ack = 1'b0;
  logic [9:0] hcount, vcount;
  logic [7:0] current_x, current_y, frame_count;
  logic       visible, hsync, vsync, vblank, frame_start, vblank_start, irq;

  int checks = 0;
  int errors = 0;
  logic [9:0] jh, jv;
  logic [7:0] jf;

`ifdef GPU_VBLANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  video_timing_m dut (
    .gpu_clk(gpu_clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .current_x(current_x), .current_y(current_y), .visible(visible),
    .hsync(hsync), .vsync(vsync), .vblank(vblank), .frame_start(frame_start),
    .vblank_start(vblank_start), .frame_count(frame_count), .irq(irq),
    .irq_ack(irq_ack)
  );

  always #5 gpu_clk = ~gpu_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int h; int v; int vis; int x; int y; int hs; int vs; int vb;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Returns just after a posedge so that sampling sits mid-cycle.
  task automatic tick(input int n);
    repeat (n) @(posedge gpu_clk);
    #2;
  endtask

  task automatic jump(input int h, input int v);
    jh = 10'(h);
    jv = 10'(v);
    force dut.h_cnt = jh;
    force dut.v_cnt = jv;
    #1;
    release dut.h_cnt;
    release dut.v_cnt;
    #1;
  endtask

  task automatic set_frames(input int f);
    jf = 8'(f);
    force dut.frame_cnt = jf;
    #1;
    release dut.frame_cnt;
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hcount"}, int'(hcount), 0);
    chk({tag, "_vcount"}, int'(vcount), 0);
    chk({tag, "_cx"}, int'(current_x), 0);
    chk({tag, "_cy"}, int'(current_y), 0);
    chk({tag, "_visible"}, int'(visible), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_vblank"}, int'(vblank), 0);
    chk({tag, "_fstart"}, int'(frame_start), 0);
    chk({tag, "_vbstart"}, int'(vblank_start), 0);
    chk({tag, "_fcount"}, int'(frame_count), 0);
    chk({tag, "_irq"}, int'(irq), 0);
  endtask

  initial begin
    int fs_cnt, vb_cnt;

    vt[0]  = '{63, 100, 0, 0, 50, 1, 1, 0};
    vt[1]  = '{64, 100, 1, 0, 50, 1, 1, 0};
    vt[2]  = '{65, 100, 1, 0, 50, 1, 1, 0};
    vt[3]  = '{66, 100, 1, 1, 50, 1, 1, 0};
    vt[4]  = '{575, 100, 1, 255, 50, 1, 1, 0};
    vt[5]  = '{576, 100, 0, 0, 50, 1, 1, 0};
    vt[6]  = '{655, 100, 0, 0, 50, 1, 1, 0};
    vt[7]  = '{656, 100, 0, 0, 50, 0, 1, 0};
    vt[8]  = '{751, 100, 0, 0, 50, 0, 1, 0};
    vt[9]  = '{752, 100, 0, 0, 50, 1, 1, 0};
    vt[10] = '{100, 479, 1, 18, 239, 1, 1, 0};
    vt[11] = '{100, 480, 0, 0, 0, 1, 1, 1};
    vt[12] = '{0, 489, 0, 0, 0, 1, 1, 1};
    vt[13] = '{0, 490, 0, 0, 0, 1, 0, 1};
    vt[14] = '{799, 491, 0, 0, 0, 1, 0, 1};
    vt[15] = '{0, 492, 0, 0, 0, 1, 1, 1};
    vt[16] = '{300, 0, 1, 118, 0, 1, 1, 0};
    vt[17] = '{575, 1, 1, 255, 0, 1, 1, 0};
    vt[18] = '{64, 2, 1, 0, 1, 1, 1, 0};
    vt[19] = '{799, 524, 0, 0, 0, 1, 1, 1};

    // Reset and release
    tick(3);
    check_reset("rst");
    rst = 1'b0;
    tick(1);
    chk("rel_hcount", int'(hcount), 1);
    chk("rel_vcount", int'(vcount), 0);
    fs_cnt = 0; vb_cnt = 0;
    repeat (2000) begin
      tick(1);
      fs_cnt += int'(frame_start);
      vb_cnt += int'(vblank_start);
    end
    chk("rel_no_fstart", fs_cnt, 0);
    chk("rel_no_vbstart", vb_cnt, 0);
    chk("rel_run_hcount", int'(hcount), 401);
    chk("rel_run_vcount", int'(vcount), 2);

    // Combinational decode vectors
    for (int i = 0; i < 20; i++) begin
      tick(1);
      jump(vt[i].h, vt[i].v);
      chk($sformatf("v%0d_visible", i), int'(visible), vt[i].vis);
      chk($sformatf("v%0d_cx", i), int'(current_x), vt[i].x);
      chk($sformatf("v%0d_cy", i), int'(current_y), vt[i].y);
      chk($sformatf("v%0d_hsync", i), int'(hsync), vt[i].hs);
      chk($sformatf("v%0d_vsync", i), int'(vsync), vt[i].vs);
      chk($sformatf("v%0d_vblank", i), int'(vblank), vt[i].vb);
    end

    // Line wrap
    jump(798, 5);
    tick(1);
    chk("lw_h799", int'(hcount), 799);
    tick(1);
    chk("lw_h0", int'(hcount), 0);
    chk("lw_v6", int'(vcount), 6);

    // Vblank entry, irq set, ack 10 clocks later
    jump(790, 479);
    vb_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      vb_cnt += int'(vblank_start);
      if (i == 10) begin
        chk("vbs_pulse", int'(vblank_start), 1);
        chk("vbs_h", int'(hcount), 0);
        chk("vbs_v", int'(vcount), 480);
        chk("vbs_vblank", int'(vblank), 1);
        chk("vbs_irq", int'(irq), int'(IRQ_ON));
      end
    end
    chk("vbs_once", vb_cnt, 1);
    chk("irq_held", int'(irq), int'(IRQ_ON));
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("irq_acked", int'(irq), 0);
    tick(3);
    chk("irq_stays_clear", int'(irq), 0);

    // Ack held across the set edge: set wins
    jump(797, 479);
    irq_ack = 1'b1;
    tick(3);
    chk("race_vbstart", int'(vblank_start), 1);
    chk("race_irq", int'(irq), int'(IRQ_ON));
    irq_ack = 1'b0;
    tick(2);
    chk("race_irq_after", int'(irq), int'(IRQ_ON));

    // Frame wrap and frame_count rollover
    jump(795, 524);
    set_frames(254);
    fs_cnt = 0;
    repeat (4) begin
      tick(1);
      fs_cnt += int'(frame_start);
    end
    chk("fw_no_early", fs_cnt, 0);
    chk("fw_fcount_pre", int'(frame_count), 254);
    tick(1);
    chk("fw_fstart", int'(frame_start), 1);
    chk("fw_origin", int'(hcount) + int'(vcount), 0);
    chk("fw_fcount255", int'(frame_count), 255);
    tick(1);
    chk("fw_fstart_drop", int'(frame_start), 0);
    jump(799, 524);
    tick(1);
    chk("fw2_fstart", int'(frame_start), 1);
    chk("fw2_fcount0", int'(frame_count), 0);

    // Mid-frame asynchronous reset, irq still pending from above
    jump(300, 200);
    set_frames(37);
    tick(1);
    chk("mf_pre_h", int'(hcount), 301);
    rst = 1'b1;
    #1;
    check_reset("mf_async");
    tick(3);
    check_reset("mf_hold");
    rst = 1'b0;
    tick(1);
    chk("mf_rel_h", int'(hcount), 1);
    chk("mf_rel_v", int'(vcount), 0);
    fs_cnt = 0; vb_cnt = 0;
    repeat (1000) begin
      tick(1);
      fs_cnt += int'(frame_start);
      vb_cnt += int'(vblank_start);
    end
    chk("mf_no_fstart", fs_cnt, 0);
    chk("mf_no_vbstart", vb_cnt, 0);
    chk("mf_run_h", int'(hcount), 201);
    chk("mf_run_v", int'(vcount), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
